dog_extrema_scan: RTL

//   Consumer of the DoG image BRAM. On a start pulse (issued once the DoG stage has

---
 rtl/dog_extrema_scan.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dog_extrema_scan.sv
// Scans interior pixels of a DoG image over a 2-cycle-latency BRAM port and flags strict local extrema.
// Latency: 12 cycles per centre, keypoint pulse one cycle after evaluation, done after the last centre.
// No backpressure: the scan runs open-loop; dog_ready is ignored while busy.
module dog_extrema_scan #(
    parameter int DIMENSION = 128,
    parameter int THRESHOLD = 3,
    parameter int ADDR_W    = 14
) (
    input  logic                    clk,
    input  logic                    rst_in_n,
    input  logic                    dog_ready,
    output logic [ADDR_W-1:0]       address,
    input  logic signed [8:0]       dog_pix,
    output logic                    busy,
    output logic                    kp_valid,
    output logic [ADDR_W/2-1:0]     kp_x,
    output logic [ADDR_W/2-1:0]     kp_y,
    output logic                    kp_is_max,
    output logic signed [8:0]       kp_value,
    output logic                    done
);

    localparam int CW = ADDR_W / 2;
    localparam logic [CW-1:0]     LAST  = CW'(DIMENSION - 2);
    localparam logic [ADDR_W-1:0] DIM_W = ADDR_W'(DIMENSION);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q;
    logic [CW-1:0]        x_q, y_q;
    logic [ADDR_W-1:0]    addr_q, fetch_addr;
    logic [ADDR_W-1:0]    row, col;
    logic [1:0]           dxp, dyp;
    logic signed [8:0]    slot_q [9];
    logic [1:0]           rd_vld_q;
    logic [3:0]           rd_k0_q, rd_k1_q;
    logic                 last_x, last_y;
    logic                 is_max, is_min, is_kp;
    logic signed [9:0]    centre_ext;
    logic [9:0]           centre_abs;

    assign last_x = (x_q == LAST);
    assign last_y = (y_q == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dog_ready) state_d = (DIMENSION < 3) ? S_DONE : S_FETCH;
            S_FETCH: if (cnt_q == 4'd8) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd1) state_d = S_EVAL;
            S_EVAL:  state_d = (last_x && last_y) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Neighbour offsets (+1 biased): centre first, then the 3x3 window in raster order.
    always_comb begin
        dxp = 2'd1;
        dyp = 2'd1;
        case (cnt_q)
            4'd1: begin dxp = 2'd0; dyp = 2'd0; end
            4'd2: begin dxp = 2'd1; dyp = 2'd0; end
            4'd3: begin dxp = 2'd2; dyp = 2'd0; end
            4'd4: begin dxp = 2'd0; dyp = 2'd1; end
            4'd5: begin dxp = 2'd2; dyp = 2'd1; end
            4'd6: begin dxp = 2'd0; dyp = 2'd2; end
            4'd7: begin dxp = 2'd1; dyp = 2'd2; end
            4'd8: begin dxp = 2'd2; dyp = 2'd2; end
            default: begin dxp = 2'd1; dyp = 2'd1; end
        endcase
        row        = ADDR_W'(y_q) + ADDR_W'(dyp) - ADDR_W'(1);
        col        = ADDR_W'(x_q) + ADDR_W'(dxp) - ADDR_W'(1);
        fetch_addr = row * DIM_W + col;
    end

    assign address = (state_q == S_FETCH) ? fetch_addr : addr_q;
    assign busy    = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_EVAL);
    assign done    = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cnt_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == S_FETCH || state_q == S_WAIT)
                cnt_q <= cnt_q + 4'd1;

            if (state_q == S_FETCH)
                addr_q <= fetch_addr;

            if (state_q == S_IDLE && dog_ready) begin
                x_q <= CW'(1);
                y_q <= CW'(1);
            end else if (state_q == S_EVAL) begin
                if (last_x) begin
                    x_q <= CW'(1);
                    y_q <= y_q + CW'(1);
                end else begin
                    x_q <= x_q + CW'(1);
                end
            end
        end
    end

    // Two-deep tag pipeline tracks which slot the returning BRAM word belongs to.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rd_vld_q <= '0;
            rd_k0_q  <= '0;
            rd_k1_q  <= '0;
            for (int i = 0; i < 9; i++) slot_q[i] <= '0;
        end else begin
            rd_vld_q <= {rd_vld_q[0], state_q == S_FETCH};
            rd_k0_q  <= cnt_q;
            rd_k1_q  <= rd_k0_q;
            if (rd_vld_q[1])
                slot_q[rd_k1_q] <= dog_pix;
        end
    end

    always_comb begin
        is_max = 1'b1;
        is_min = 1'b1;
        for (int i = 1; i < 9; i++) begin
            if (!(slot_q[0] > slot_q[i])) is_max = 1'b0;
            if (!(slot_q[0] < slot_q[i])) is_min = 1'b0;
        end
        centre_ext = {slot_q[0][8], slot_q[0]};
        centre_abs = centre_ext[9] ? 10'(-centre_ext) : 10'(centre_ext);
        is_kp      = (is_max || is_min) && (centre_abs > 10'(THRESHOLD));
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            kp_valid  <= 1'b0;
            kp_x      <= '0;
            kp_y      <= '0;
            kp_is_max <= 1'b0;
            kp_value  <= '0;
        end else begin
            kp_valid <= (state_q == S_EVAL) && is_kp;
            if (state_q == S_EVAL && is_kp) begin
                kp_x      <= x_q;
                kp_y      <= y_q;
                kp_is_max <= is_max;
                kp_value  <= slot_q[0];
            end
        end
    end

endmodule
